// File: rtl/log_mag_accum_pkg.sv
// Shared constants and types for the log-magnitude accumulator stage.
package log_mag_accum_pkg;

    // Fractional bits of every log value and of the accumulated result.
    localparam int FRAC      = 8;
    // Signed result width: magnitude up to 128.0 plus a sign bit.
    localparam int ACC_W     = FRAC + 9;
    // Width of one unsigned Q5.FRAC log term.
    localparam int LOG_W     = 5 + FRAC;
    // Width of each incoming complex-difference component.
    localparam int DIFF_W    = 16;

    localparam int NUM_ZEROS = 4;
    localparam int NUM_POLES = 4;
    localparam int NUM_TERMS = NUM_ZEROS + NUM_POLES;

    // Saturation codes reported when a pole or zero is hit exactly.
    localparam logic signed [ACC_W-1:0] LOG_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] LOG_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/log_mag_accum_if.sv
// Difference-set input and result output of the log-magnitude accumulator.
//
// Handshake: a transfer happens on a rising clk edge where both valid and
// ready are high. in_valid/data are held by the producer until accepted;
// out_valid/log_mag/zero_hit/pole_hit are held by the block until accepted.
interface log_mag_accum_if
    import log_mag_accum_pkg::*;
#(
    parameter int ACC_W_P = ACC_W
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [DIFF_W-1:0]  zero_diff_re [NUM_ZEROS];
    logic signed [DIFF_W-1:0]  zero_diff_im [NUM_ZEROS];
    logic signed [DIFF_W-1:0]  pole_diff_re [NUM_POLES];
    logic signed [DIFF_W-1:0]  pole_diff_im [NUM_POLES];
    logic                      out_valid;
    logic                      out_ready;
    logic signed [ACC_W_P-1:0] log_mag;
    logic                      zero_hit;
    logic                      pole_hit;

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid, zero_diff_re, zero_diff_im, pole_diff_re, pole_diff_im,
        output out_ready,
        input  in_ready, out_valid, log_mag, zero_hit, pole_hit
    );

    // Accumulator block side.
    modport slave (
        input  in_valid, zero_diff_re, zero_diff_im, pole_diff_re, pole_diff_im,
        input  out_ready,
        output in_ready, out_valid, log_mag, zero_hit, pole_hit
    );

endinterface

// File: rtl/log_mag_accum_log2_approx.sv
// Mitchell log2 approximation: leading-one position as the integer part and
// the FRAC bits just below the leading one as the fraction (Q5.FRAC).
module log2_approx #(
    parameter int FRAC = 8
) (
    input  logic [31:0]       i_value,
    output logic [5+FRAC-1:0] o_log,
    output logic              o_is_zero
);

    logic [4:0]  w_lead;
    logic [31:0] w_norm;

    // Priority encoder: the highest set bit wins.
    always_comb begin
        w_lead = '0;
        for (int i = 0; i < 32; i++) begin
            if (i_value[i]) begin
                w_lead = 5'(i);
            end
        end
    end

    // Normalise so the leading one sits at bit 31; bits below it are the
    // fraction, zero-filled automatically when the leading one is low.
    assign w_norm    = i_value << (5'd31 - w_lead);
    assign o_log     = {w_lead, w_norm[30 -: FRAC]};
    assign o_is_zero = (i_value == '0);

endmodule

// File: rtl/log_mag_accum.sv
// Accumulates log2|H(z)|^2 over 4 zero and 4 pole differences, one term per
// cycle, and reports saturation codes when a difference is exactly zero.
module log_mag_accum
    import log_mag_accum_pkg::*;
#(
    parameter int FRAC_P  = FRAC,
    parameter int ACC_W_P = ACC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    log_mag_accum_if.slave        bus,
    output state_t                o_state
);

    localparam int LOG_W_P = 5 + FRAC_P;
    localparam logic signed [ACC_W_P-1:0] L_MAX = {1'b0, {(ACC_W_P-1){1'b1}}};
    localparam logic signed [ACC_W_P-1:0] L_MIN = {1'b1, {(ACC_W_P-1){1'b0}}};
    localparam logic [2:0] LAST_IDX = 3'(NUM_TERMS - 1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [2:0]                 r_idx;
    logic signed [DIFF_W-1:0]   r_zero_re [NUM_ZEROS];
    logic signed [DIFF_W-1:0]   r_zero_im [NUM_ZEROS];
    logic signed [DIFF_W-1:0]   r_pole_re [NUM_POLES];
    logic signed [DIFF_W-1:0]   r_pole_im [NUM_POLES];
    logic signed [ACC_W_P-1:0]  r_acc;
    logic signed [ACC_W_P-1:0]  r_log_mag;
    logic                       r_zero_hit;
    logic                       r_pole_hit;

    logic                       w_in_ready;
    logic                       w_out_valid;
    logic                       w_accept;
    logic                       w_run;
    logic                       w_is_pole;
    logic signed [DIFF_W-1:0]   w_re;
    logic signed [DIFF_W-1:0]   w_im;
    logic signed [31:0]         w_re_ext;
    logic signed [31:0]         w_im_ext;
    logic signed [31:0]         w_re_sq;
    logic signed [31:0]         w_im_sq;
    logic [31:0]                w_mag2;
    logic [LOG_W_P-1:0]         w_log;
    logic                       w_log_zero;
    logic signed [ACC_W_P-1:0]  w_log_ext;
    logic signed [ACC_W_P-1:0]  w_acc_next;
    logic                       w_zero_hit_next;
    logic                       w_pole_hit_next;
    logic signed [ACC_W_P-1:0]  w_final;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_accept     = 1'b0;
        w_run        = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Select the current term: indices 0-3 are zeros, 4-7 are poles.
    always_comb begin
        w_is_pole = r_idx[2];
        w_re      = r_zero_re[r_idx[1:0]];
        w_im      = r_zero_im[r_idx[1:0]];
        if (w_is_pole) begin
            w_re = r_pole_re[r_idx[1:0]];
            w_im = r_pole_im[r_idx[1:0]];
        end
    end

    // Squared magnitude; the sum can reach 2^31, so it is kept unsigned.
    assign w_re_ext = 32'(w_re);
    assign w_im_ext = 32'(w_im);
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;
    assign w_mag2   = $unsigned(w_re_sq) + $unsigned(w_im_sq);

    log2_approx #(
        .FRAC (FRAC_P)
    ) u_log2 (
        .i_value   (w_mag2),
        .o_log     (w_log),
        .o_is_zero (w_log_zero)
    );

    assign w_log_ext = $signed({{(ACC_W_P-LOG_W_P){1'b0}}, w_log});

    // Accumulate one term: zeros add, poles subtract, exact zeros only flag.
    always_comb begin
        w_acc_next      = r_acc;
        w_zero_hit_next = r_zero_hit;
        w_pole_hit_next = r_pole_hit;
        if (w_log_zero) begin
            if (w_is_pole) begin
                w_pole_hit_next = 1'b1;
            end else begin
                w_zero_hit_next = 1'b1;
            end
        end else if (w_is_pole) begin
            w_acc_next = r_acc - w_log_ext;
        end else begin
            w_acc_next = r_acc + w_log_ext;
        end
    end

    // Final result including the last term; a pole hit outranks a zero hit.
    always_comb begin
        w_final = w_acc_next;
        if (w_pole_hit_next) begin
            w_final = L_MAX;
        end else if (w_zero_hit_next) begin
            w_final = L_MIN;
        end
    end

    // Datapath: capture the set on accept, step one term per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_acc      <= '0;
            r_log_mag  <= '0;
            r_zero_hit <= 1'b0;
            r_pole_hit <= 1'b0;
            for (int i = 0; i < NUM_ZEROS; i++) begin
                r_zero_re[i] <= '0;
                r_zero_im[i] <= '0;
            end
            for (int i = 0; i < NUM_POLES; i++) begin
                r_pole_re[i] <= '0;
                r_pole_im[i] <= '0;
            end
        end else if (w_accept) begin
            r_idx      <= '0;
            r_acc      <= '0;
            r_zero_hit <= 1'b0;
            r_pole_hit <= 1'b0;
            for (int i = 0; i < NUM_ZEROS; i++) begin
                r_zero_re[i] <= bus.zero_diff_re[i];
                r_zero_im[i] <= bus.zero_diff_im[i];
            end
            for (int i = 0; i < NUM_POLES; i++) begin
                r_pole_re[i] <= bus.pole_diff_re[i];
                r_pole_im[i] <= bus.pole_diff_im[i];
            end
        end else if (w_run) begin
            r_idx      <= r_idx + 3'd1;
            r_acc      <= w_acc_next;
            r_zero_hit <= w_zero_hit_next;
            r_pole_hit <= w_pole_hit_next;
            if (r_idx == LAST_IDX) begin
                r_log_mag <= w_final;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.log_mag   = r_log_mag;
    assign bus.zero_hit  = r_zero_hit;
    assign bus.pole_hit  = r_pole_hit;
    assign o_state       = r_state;

endmodule

// File: tb/tb_log_mag_accum.sv
// Directed bench for log_mag_accum with a queue-based result scoreboard.
module tb_log_mag_accum;
    import log_mag_accum_pkg::*;

    localparam int W = ACC_W + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    log_mag_accum_if bus ();
    state_t dbg_state;

    log_mag_accum dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .o_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int accept_cyc = 0;
    int valid_cyc  = 0;
    logic prev_valid = 1'b0;

    logic signed [15:0] v_zr [4];
    logic signed [15:0] v_zi [4];
    logic signed [15:0] v_pr [4];
    logic signed [15:0] v_pi [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h (%0d) want 0x%0h (%0d)", name, got, $signed(got), want, $signed(want));
        end
    endtask

    task automatic push_exp(input int lm, input logic zh, input logic ph);
        exp_q.push_back({ACC_W'(lm), zh, ph});
    endtask

    task automatic set_all(input logic signed [15:0] zr, input logic signed [15:0] zi,
                           input logic signed [15:0] pr, input logic signed [15:0] pi);
        for (int i = 0; i < 4; i++) begin
            v_zr[i] = zr; v_zi[i] = zi; v_pr[i] = pr; v_pi[i] = pi;
        end
    endtask

    // ---------------- driver ----------------
    // Presents the current vector set and returns just after the accept edge.
    task automatic send_set();
        int tmo;
        for (int i = 0; i < 4; i++) begin
            bus.zero_diff_re[i] = v_zr[i];
            bus.zero_diff_im[i] = v_zi[i];
            bus.pole_diff_re[i] = v_pr[i];
            bus.pole_diff_im[i] = v_pi[i];
        end
        bus.in_valid = 1'b1;
        tmo = 0;
        while (!bus.in_ready && tmo < 100) begin
            @(posedge clk); #1;
            tmo++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, want 1", tmo);
        end
        @(posedge clk); #1;
        accept_cyc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int tmo;
        tmo = 0;
        while (exp_q.size() != 0 && tmo < 100) begin
            @(posedge clk); #1;
            tmo++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL result_timeout: %0d results outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic signed [ACC_W-1:0] e_log;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            // Index of the first edge at which the result is presented.
            if (bus.out_valid && !prev_valid) valid_cyc = cyc + 1;
            prev_valid = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: got log_mag %0d, want no result", bus.log_mag);
                end else begin
                    e = exp_q.pop_front();
                    e_log = e[W-1:2];
                    check("log_mag",  32'(bus.log_mag), 32'(e_log));
                    check("zero_hit", 32'(bus.zero_hit), 32'(e[1]));
                    check("pole_hit", 32'(bus.pole_hit), 32'(e[0]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int tmo;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_all(16'sd0, 16'sd0, 16'sd0, 16'sd0);
        for (int i = 0; i < 4; i++) begin
            bus.zero_diff_re[i] = '0; bus.zero_diff_im[i] = '0;
            bus.pole_diff_re[i] = '0; bus.pole_diff_im[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready",  32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_log_mag",   32'(bus.log_mag), 32'd0);
        check("rst_zero_hit",  32'(bus.zero_hit), 32'd0);
        check("rst_pole_hit",  32'(bus.pole_hit), 32'd0);
        check("rst_state",     32'(dbg_state), 32'(IDLE));

        // (3,4): mag2=25 -> 0x490 per term, zeros and poles cancel.
        set_all(16'sd3, 16'sd4, 16'sd3, 16'sd4);
        push_exp(0, 1'b0, 1'b0);
        send_set();
        wait_drain();
        check("latency", 32'(valid_cyc - accept_cyc), 32'd9);

        // Zeros (16,0) -> 8.0 each, poles (1,0) -> 0: 32.0.
        set_all(16'sd16, 16'sd0, 16'sd1, 16'sd0);
        push_exp(32'h2000, 1'b0, 1'b0);
        send_set();
        wait_drain();

        // Zeros at the extreme corner: 2^31 -> 31.0 each, total 124.0.
        set_all(-16'sd32768, -16'sd32768, 16'sd1, 16'sd0);
        push_exp(31744, 1'b0, 1'b0);
        send_set();
        wait_drain();

        // Negative result: 4*(4.5625 - 8.0) = -13.75 = -3520.
        set_all(16'sd3, 16'sd4, 16'sd16, 16'sd0);
        push_exp(-3520, 1'b0, 1'b0);
        send_set();
        wait_drain();

        // Exact zero hit -> min negative.
        set_all(16'sd1, 16'sd0, 16'sd1, 16'sd0);
        v_zr[0] = 16'sd0; v_zi[0] = 16'sd0;
        push_exp(-65536, 1'b1, 1'b0);
        send_set();
        wait_drain();

        // Zero and pole hit together -> pole wins, max positive.
        v_pr[2] = 16'sd0; v_pi[2] = 16'sd0;
        push_exp(65535, 1'b1, 1'b1);
        send_set();
        wait_drain();

        // Back-pressure: result must hold while out_ready is low.
        bus.out_ready = 1'b0;
        set_all(16'sd16, 16'sd0, 16'sd1, 16'sd0);
        push_exp(32'h2000, 1'b0, 1'b0);
        send_set();
        tmo = 0;
        while (!bus.out_valid && tmo < 50) begin
            @(posedge clk); #1;
            tmo++;
        end
        for (int k = 0; k < 5; k++) begin
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_log_mag",   32'(bus.log_mag), 32'h2000);
            check("stall_flags",     {30'd0, bus.zero_hit, bus.pole_hit}, 32'd0);
            check("stall_in_ready",  32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready",  32'(bus.in_ready), 32'd1);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_state",     32'(dbg_state), 32'(IDLE));
        wait_drain();

        // Back-to-back sets with independent results.
        set_all(16'sd3, 16'sd4, 16'sd3, 16'sd4);
        push_exp(0, 1'b0, 1'b0);
        send_set();
        set_all(-16'sd32768, -16'sd32768, 16'sd1, 16'sd0);
        push_exp(31744, 1'b0, 1'b0);
        send_set();
        wait_drain();

        // Reset in the middle of RUN (term index 4) aborts the set.
        set_all(-16'sd32768, -16'sd32768, 16'sd0, 16'sd0);
        send_set();
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("mid_state_run", 32'(dbg_state), 32'(RUN));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready",  32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_log_mag",   32'(bus.log_mag), 32'd0);
        check("abort_flags",     {30'd0, bus.zero_hit, bus.pole_hit}, 32'd0);
        check("abort_state",     32'(dbg_state), 32'(IDLE));

        set_all(16'sd16, 16'sd0, 16'sd1, 16'sd0);
        push_exp(32'h2000, 1'b0, 1'b0);
        send_set();
        wait_drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
